// File: rtl/tank_pkg.sv
// Shared tank-game constants: direction and tile codes, tile-map geometry,
// the bullet collision FSM states and the tile-index helper.
package tank_pkg;

    localparam logic [1:0] ICON_UP    = 2'd0;
    localparam logic [1:0] ICON_DOWN  = 2'd1;
    localparam logic [1:0] ICON_LEFT  = 2'd2;
    localparam logic [1:0] ICON_RIGHT = 2'd3;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_BRICK = 2'd1;
    localparam logic [1:0] TILE_STEEL = 2'd2;
    localparam logic [1:0] TILE_WATER = 2'd3;

    localparam int MAP_COLS   = 20;
    localparam int TILE_SHIFT = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MAP_REQ,
        ST_MAP_WAIT,
        ST_BRICK_WR,
        ST_DESTROY,
        ST_EXPLODE
    } bc_state_t;

    // Row-major tile index with 20 columns: ty*16 + ty*4 + tx, no multiplier.
    function automatic logic [8:0] tile_index(input logic [9:0] x, input logic [8:0] y);
        logic [8:0] tx;
        logic [8:0] ty;
        tx = {4'b0, x[9:TILE_SHIFT]};
        ty = {5'b0, y[8:TILE_SHIFT]};
        return (ty << 4) + (ty << 2) + tx;
    endfunction

endpackage

// File: rtl/bullet_collision_explosion_timer.sv
// Down-counter for the explosion duration: load starts it at EXPLOSION_CYCLES-1,
// done_o is high during the cycle the count sits at zero.
module explosion_timer #(
    parameter int EXPLOSION_CYCLES = 25_000_000
) (
    input  logic clk25,
    input  logic reset,
    input  logic load_i,
    output logic done_o
);

    localparam int CW = (EXPLOSION_CYCLES > 1) ? $clog2(EXPLOSION_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(EXPLOSION_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            cnt_d    = LOAD_VAL;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/bullet_collision.sv
// Bullet collision responder: tank/bounds/tile-map checks, brick clearing and
// explosion timing. Define BULLET_COLLISION_SCORE_EN to build the hit counter.
module bullet_collision
    import tank_pkg::*;
#(
    parameter int SCREEN_W         = 640,
    parameter int SCREEN_H         = 480,
    parameter int TANK_SIZE        = 32,
    parameter int EXPLOSION_CYCLES = 25_000_000
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [9:0] bullet_x,
    input  logic [8:0] bullet_y,
    input  logic       bullet_act,
    input  logic [9:0] enemy_x,
    input  logic [8:0] enemy_y,
    output logic       map_rd,
    output logic [8:0] map_addr,
    input  logic [1:0] map_data,
    input  logic       map_valid,
    output logic       map_wr,
    output logic       des_bullet,
    output logic       explosion_flag,
    output logic [9:0] exp_x,
    output logic [8:0] exp_y,
    output logic       hit_tank,
    output logic [7:0] score
);

    bc_state_t  state_q, state_d;
    logic [9:0] last_x_q, last_x_d;
    logic [8:0] last_y_q, last_y_d;
    logic       first_q, first_d;
    logic       abort_q, abort_d;
    logic       map_rd_q, map_rd_d;
    logic [8:0] map_addr_q, map_addr_d;
    logic       map_wr_q, map_wr_d;
    logic       des_q, des_d;
    logic       flag_q, flag_d;
    logic [9:0] exp_x_q, exp_x_d;
    logic [8:0] exp_y_q, exp_y_d;
    logic       hit_q, hit_d;

    logic        pos_new;
    logic [10:0] dx, dy;
    logic        tank_hit, out_of_bounds;
    logic        timer_load, timer_done;

    assign pos_new = bullet_act &&
                     (first_q || (bullet_x != last_x_q) || (bullet_y != last_y_q));

    // 11-bit differences: a bullet left of / above the tank wraps to a large value.
    assign dx = {1'b0, last_x_q} - {1'b0, enemy_x};
    assign dy = {2'b0, last_y_q} - {2'b0, enemy_y};
    assign tank_hit      = (dx < 11'(TANK_SIZE)) && (dy < 11'(TANK_SIZE));
    assign out_of_bounds = ({1'b0, last_x_q} >= 11'(SCREEN_W)) ||
                           ({1'b0, last_y_q} >= 10'(SCREEN_H));

    assign timer_load = (state_q == ST_DESTROY);

    explosion_timer #(
        .EXPLOSION_CYCLES(EXPLOSION_CYCLES)
    ) u_timer (
        .clk25 (clk25),
        .reset (reset),
        .load_i(timer_load),
        .done_o(timer_done)
    );

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (pos_new) state_d = ST_CHECK;
            ST_CHECK:    state_d = (tank_hit || out_of_bounds) ? ST_DESTROY : ST_MAP_REQ;
            ST_MAP_REQ:  state_d = ST_MAP_WAIT;
            ST_MAP_WAIT: begin
                if (map_valid) begin
                    if (abort_q || !bullet_act) begin
                        state_d = ST_IDLE;
                    end else begin
                        case (map_data)
                            TILE_BRICK: state_d = ST_BRICK_WR;
                            TILE_STEEL: state_d = ST_DESTROY;
                            default:    state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_BRICK_WR: state_d = ST_DESTROY;
            ST_DESTROY:  state_d = ST_EXPLODE;
            ST_EXPLODE:  if (timer_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        first_d    = first_q;
        abort_d    = abort_q;
        map_rd_d   = 1'b0;
        map_addr_d = map_addr_q;
        map_wr_d   = 1'b0;
        des_d      = 1'b0;
        hit_d      = 1'b0;
        flag_d     = flag_q;
        exp_x_d    = exp_x_q;
        exp_y_d    = exp_y_q;
        case (state_q)
            ST_IDLE: begin
                if (pos_new) begin
                    last_x_d = bullet_x;
                    last_y_d = bullet_y;
                    first_d  = 1'b0;
                end
            end
            ST_CHECK:    hit_d = tank_hit;
            ST_MAP_REQ: begin
                map_rd_d   = 1'b1;
                map_addr_d = tile_index(last_x_q, last_y_q);
                abort_d    = 1'b0;
            end
            ST_MAP_WAIT: if (!bullet_act) abort_d = 1'b1;
            ST_BRICK_WR: map_wr_d = 1'b1;
            ST_DESTROY: begin
                des_d   = 1'b1;
                flag_d  = 1'b1;
                exp_x_d = last_x_q;
                exp_y_d = last_y_q;
            end
            ST_EXPLODE: begin
                if (timer_done) begin
                    flag_d  = 1'b0;
                    first_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            last_x_q   <= '0;
            last_y_q   <= '0;
            first_q    <= 1'b1;
            abort_q    <= 1'b0;
            map_rd_q   <= 1'b0;
            map_addr_q <= '0;
            map_wr_q   <= 1'b0;
            des_q      <= 1'b0;
            hit_q      <= 1'b0;
            flag_q     <= 1'b0;
            exp_x_q    <= '0;
            exp_y_q    <= '0;
        end else begin
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            first_q    <= first_d;
            abort_q    <= abort_d;
            map_rd_q   <= map_rd_d;
            map_addr_q <= map_addr_d;
            map_wr_q   <= map_wr_d;
            des_q      <= des_d;
            hit_q      <= hit_d;
            flag_q     <= flag_d;
            exp_x_q    <= exp_x_d;
            exp_y_q    <= exp_y_d;
        end
    end

`ifdef BULLET_COLLISION_SCORE_EN
    logic [7:0] score_q;

    // Counts alongside hit_tank so both outputs change on the same edge.
    always_ff @(posedge clk25) begin
        if (reset) begin
            score_q <= '0;
        end else if (hit_d && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

    assign map_rd         = map_rd_q;
    assign map_addr       = map_addr_q;
    assign map_wr         = map_wr_q;
    assign des_bullet     = des_q;
    assign explosion_flag = flag_q;
    assign exp_x          = exp_x_q;
    assign exp_y          = exp_y_q;
    assign hit_tank       = hit_q;

endmodule

// File: tb/tb_bullet_collision.sv
// Self-checking bench for bullet_collision: directed shots plus random shots
// against a position/tile-level model of the collision rules.
module tb_bullet_collision;

    localparam int N_EXP = 8;
    localparam int WIN   = 32;

    logic       clk25 = 1'b0;
    logic       reset;
    logic [9:0] bullet_x;
    logic [8:0] bullet_y;
    logic       bullet_act;
    logic [9:0] enemy_x;
    logic [8:0] enemy_y;
    logic       map_rd;
    logic [8:0] map_addr;
    logic [1:0] map_data;
    logic       map_valid;
    logic       map_wr;
    logic       des_bullet;
    logic       explosion_flag;
    logic [9:0] exp_x;
    logic [8:0] exp_y;
    logic       hit_tank;
    logic [7:0] score;

    always #20 clk25 = ~clk25;

    bullet_collision #(
        .SCREEN_W(640), .SCREEN_H(480), .TANK_SIZE(32), .EXPLOSION_CYCLES(N_EXP)
    ) dut (
        .clk25(clk25), .reset(reset),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_act(bullet_act),
        .enemy_x(enemy_x), .enemy_y(enemy_y),
        .map_rd(map_rd), .map_addr(map_addr), .map_data(map_data), .map_valid(map_valid),
        .map_wr(map_wr), .des_bullet(des_bullet), .explosion_flag(explosion_flag),
        .exp_x(exp_x), .exp_y(exp_y), .hit_tank(hit_tank), .score(score)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_first = 1;
    int m_lx = 0;
    int m_ly = 0;
    int m_score = 0;
    logic [1:0] mem [0:511];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_map_rd"}, 32'(map_rd), 0);
        chk({tag, "_map_wr"}, 32'(map_wr), 0);
        chk({tag, "_des"}, 32'(des_bullet), 0);
        chk({tag, "_hit"}, 32'(hit_tank), 0);
        chk({tag, "_flag"}, 32'(explosion_flag), 0);
        chk({tag, "_exp_x"}, 32'(exp_x), 0);
        chk({tag, "_exp_y"}, 32'(exp_y), 0);
        chk({tag, "_map_addr"}, 32'(map_addr), 0);
        chk({tag, "_score"}, 32'(score), 0);
    endtask

    // kind: 0 no check, 1 tank, 2 bounds, 3 map no-hit, 4 steel, 5 brick
    task automatic shot(input int bx, input int by, input int lat, input bit drop);
        int kind, idx, dxm, dym;
        int hit_cnt, hit_at, des_cnt, des_at, rd_cnt, rd_at, rd_addr;
        int wr_cnt, wr_at, wr_addr, fl_cnt, fl_at, ex_x, ex_y;
        int e_des_at, e_destroy;
        kind = 0; idx = 0;
        if (m_first != 0 || bx != m_lx || by != m_ly) begin
            m_lx = bx; m_ly = by; m_first = 0;
            dxm = (bx - int'(enemy_x)) & 2047;
            dym = (by - int'(enemy_y)) & 2047;
            if (dxm < 32 && dym < 32) kind = 1;
            else if (bx >= 640 || by >= 480) kind = 2;
            else begin
                idx = (by / 32) * 20 + bx / 32;
                if (drop) kind = 3;
                else if (mem[idx] == 2'd2) kind = 4;
                else if (mem[idx] == 2'd1) kind = 5;
                else kind = 3;
            end
        end
        e_destroy = (kind == 1 || kind == 2 || kind == 4 || kind == 5) ? 1 : 0;
        e_des_at = (kind <= 2) ? 3 : (kind == 4) ? 5 + lat : 6 + lat;

        hit_cnt = 0; hit_at = 0; des_cnt = 0; des_at = 0; rd_cnt = 0; rd_at = 0;
        rd_addr = 0; wr_cnt = 0; wr_at = 0; wr_addr = 0; fl_cnt = 0; fl_at = 0;
        ex_x = 0; ex_y = 0;
        @(negedge clk25);
        bullet_x = 10'(bx); bullet_y = 9'(by); bullet_act = 1'b1;
        for (int t = 1; t <= WIN; t++) begin
            @(posedge clk25); #1;
            if (map_valid) map_valid = 1'b0;
            if (hit_tank) begin hit_cnt++; if (hit_at == 0) hit_at = t; end
            if (des_bullet) begin
                des_cnt++; if (des_at == 0) des_at = t;
                ex_x = int'(exp_x); ex_y = int'(exp_y);
                bullet_act = 1'b0;
            end
            if (map_rd) begin
                rd_cnt++; if (rd_at == 0) begin rd_at = t; rd_addr = int'(map_addr); end
                if (drop) bullet_act = 1'b0;
            end
            if (map_wr) begin
                wr_cnt++; if (wr_at == 0) begin wr_at = t; wr_addr = int'(map_addr); end
                mem[map_addr] = 2'd0;
            end
            if (explosion_flag) begin fl_cnt++; if (fl_at == 0) fl_at = t; end
            if (rd_at != 0 && t == rd_at + lat) begin
                map_data = mem[rd_addr[8:0]];
                map_valid = 1'b1;
            end
        end
        if (e_destroy != 0) m_first = 1;
`ifdef BULLET_COLLISION_SCORE_EN
        if (kind == 1 && m_score < 255) m_score++;
`endif
        chk("hit_count", hit_cnt, (kind == 1) ? 1 : 0);
        chk("des_count", des_cnt, e_destroy);
        chk("rd_count", rd_cnt, (kind >= 3) ? 1 : 0);
        chk("wr_count", wr_cnt, (kind == 5) ? 1 : 0);
        chk("flag_cycles", fl_cnt, e_destroy * N_EXP);
        chk("score", 32'(score), m_score);
        if (kind == 1) chk("hit_at", hit_at, 2);
        if (e_destroy != 0) begin
            chk("des_at", des_at, e_des_at);
            chk("flag_at", fl_at, e_des_at);
            chk("exp_x", ex_x, bx);
            chk("exp_y", ex_y, by);
        end
        if (kind >= 3) begin
            chk("rd_at", rd_at, 3);
            chk("rd_addr", rd_addr, idx);
        end
        if (kind == 5) begin
            chk("wr_at", wr_at, 5 + lat);
            chk("wr_addr", wr_addr, idx);
        end
        $display("shot (%0d,%0d) enemy (%0d,%0d) kind=%0d lat=%0d drop=%0d des_at=%0d",
                 bx, by, enemy_x, enemy_y, kind, lat, drop, des_at);
    endtask

    initial begin
        int bx, by, r;
        reset = 1'b1; bullet_x = '0; bullet_y = '0; bullet_act = 1'b0;
        enemy_x = 10'd90; enemy_y = 9'd90; map_data = '0; map_valid = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 2'($urandom_range(0, 3));
        repeat (3) @(posedge clk25);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk25);
        reset = 1'b0;

        // Directed cases
        shot(100, 100, 1, 1'b0);
        shot(1023, 200, 1, 1'b0);
        mem[22] = 2'd1;
        shot(70, 40, 3, 1'b0);
        mem[22] = 2'd3;
        shot(71, 40, 2, 1'b0);
        mem[22] = 2'd2;
        shot(72, 40, 2, 1'b0);
        enemy_x = 10'd690; enemy_y = 9'd100;
        shot(700, 110, 1, 1'b0);
        enemy_x = 10'd500; enemy_y = 9'd400;
        mem[(200 / 32) * 20 + 300 / 32] = 2'd2;
        shot(300, 200, 4, 1'b1);
        shot(301, 200, 2, 1'b0);

        // Reset while a map read is outstanding
        @(negedge clk25);
        bullet_x = 10'd200; bullet_y = 9'd300; bullet_act = 1'b1;
        repeat (4) @(posedge clk25);
        #1;
        reset = 1'b1; bullet_act = 1'b0;
        @(posedge clk25); #1;
        chk_idle_outputs("mid_reset");
        @(negedge clk25);
        reset = 1'b0;
        m_first = 1; m_lx = 0; m_ly = 0; m_score = 0;
        $display("reset applied in MAP_WAIT");

        // Random shots
        for (int n = 0; n < 120; n++) begin
            enemy_x = 10'($urandom_range(0, 607));
            enemy_y = 9'($urandom_range(0, 447));
            r = int'($urandom_range(0, 4));
            if (r == 0) begin
                bx = (int'(enemy_x) + int'($urandom_range(0, 40)) - 4) & 1023;
                by = (int'(enemy_y) + int'($urandom_range(0, 40)) - 4) & 511;
            end else if (r == 1) begin
                bx = int'($urandom_range(0, 1023));
                by = int'($urandom_range(480, 511));
            end else begin
                bx = int'($urandom_range(0, 639));
                by = int'($urandom_range(0, 479));
            end
            shot(bx, by, int'($urandom_range(1, 6)), ($urandom_range(0, 7) == 0));
        end

        // Repeated tank hits to exercise score saturation
        enemy_x = 10'd90; enemy_y = 9'd90;
        for (int n = 0; n < 260; n++) shot(100 + (n % 2), 100, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
